// File: rtl/a_seq_pkg.sv
// a_seq_pkg: shared state, phase and width constants for the A-line generator and detector
package a_seq_pkg;
  localparam int HOLD_W_DEF = 8;
  localparam int REP_W_DEF  = 4;
  typedef enum logic [4:0] {
    IDLE = 5'b10000,
    HI1  = 5'b01000,
    LO1  = 5'b00100,
    HI2  = 5'b00010,
    LO2  = 5'b00001
  } state_t;
  localparam logic [1:0] PH_HI1 = 2'd0;
  localparam logic [1:0] PH_LO1 = 2'd1;
  localparam logic [1:0] PH_HI2 = 2'd2;
  localparam logic [1:0] PH_LO2 = 2'd3;
endpackage

// File: rtl/a_seq_hold_cnt.sv
// a_seq_hold_cnt: loadable down-counter whose last flag marks the final cycle of a phase
module a_seq_hold_cnt #(
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              en,
  output logic              last
);
  logic [HOLD_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en) cnt <= cnt - HOLD_W'(1);
  assign last = cnt == HOLD_W'(1);
endmodule

// File: rtl/a_seq_gen.sv
// a_seq_gen: emits programmable 1-0-1-0 frames on a_out for the A-line detector
module a_seq_gen
  import a_seq_pkg::*;
#(
  parameter int HOLD_W = HOLD_W_DEF,
  parameter int REP_W  = REP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [HOLD_W-1:0] hold_hi,
  input  logic [HOLD_W-1:0] hold_lo,
  input  logic [REP_W-1:0]  reps,
  output logic              a_out,
  output logic              busy,
  output logic              done,
  output logic [1:0]        phase
);
  state_t            state;
  logic [HOLD_W-1:0] hh_q, hl_q, hh_in;
  logic [REP_W-1:0]  frames_q;
  logic              go, active, last, more;
  logic              cnt_load, cnt_en;
  logic [HOLD_W-1:0] cnt_val;
  assign hh_in  = (hold_hi == '0) ? HOLD_W'(1) : hold_hi;
  assign go     = state == IDLE && start && !abort;
  assign active = state inside {HI1, LO1, HI2, LO2};
  assign more   = frames_q != REP_W'(1);
  // One counter serves every phase: reload with the next phase's hold on the last cycle, clear when leaving.
  always_comb begin
    cnt_load = (state == IDLE) ? go : (abort || last || !active);
    cnt_en   = active && !abort && !last;
    cnt_val  = (state == IDLE) ? hh_in :
               (abort || !active) ? '0 :
               (state == HI1 || state == HI2) ? hl_q :
               (state == LO1) ? hh_q :
               more ? hh_q : '0;
  end
  a_seq_hold_cnt #(.HOLD_W(HOLD_W)) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .last     (last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      a_out    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      phase    <= PH_HI1;
      hh_q     <= '0;
      hl_q     <= '0;
      frames_q <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        a_out <= 1'b0;
        busy  <= 1'b0;
        phase <= PH_HI1;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            hh_q     <= hh_in;
            hl_q     <= (hold_lo == '0) ? HOLD_W'(1) : hold_lo;
            frames_q <= (reps == '0) ? REP_W'(1) : reps;
            state    <= HI1;
            a_out    <= 1'b1;
            busy     <= 1'b1;
            phase    <= PH_HI1;
          end
          HI1: if (last) begin
            state <= LO1;
            a_out <= 1'b0;
            phase <= PH_LO1;
          end
          LO1: if (last) begin
            state <= HI2;
            a_out <= 1'b1;
            phase <= PH_HI2;
          end
          HI2: if (last) begin
            state <= LO2;
            a_out <= 1'b0;
            phase <= PH_LO2;
          end
          LO2: if (last) begin
            frames_q <= frames_q - REP_W'(1);
            state    <= more ? HI1 : IDLE;
            a_out    <= more;
            busy     <= more;
            done     <= !more;
            phase    <= PH_HI1;
          end
          default: begin
            state    <= IDLE;
            a_out    <= 1'b0;
            busy     <= 1'b0;
            phase    <= PH_HI1;
            hh_q     <= '0;
            hl_q     <= '0;
            frames_q <= '0;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_a_seq_gen.sv
// tb_a_seq_gen: randomized frame checks of a_seq_gen against a per-cycle waveform model
module tb_a_seq_gen;
  localparam int HOLD_W = 8;
  localparam int REP_W  = 4;
  localparam logic [4:0] IDLE_V = 5'b00000;
  localparam logic [4:0] DONE_V = 5'b00100;
  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [HOLD_W-1:0] hold_hi = '0, hold_lo = '0;
  logic [REP_W-1:0]  reps = '0;
  logic              a_out, busy, done;
  logic [1:0]        phase;
  logic [4:0]        obs;
  logic [4:0]        exp_q[$];
  int                errors = 0, checks = 0;
  a_seq_gen #(.HOLD_W(HOLD_W), .REP_W(REP_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .hold_hi (hold_hi),
    .hold_lo (hold_lo),
    .reps    (reps),
    .a_out   (a_out),
    .busy    (busy),
    .done    (done),
    .phase   (phase)
  );
  assign obs = {a_out, busy, done, phase};
  always #5 clk = ~clk;
  // Expected {a_out,busy,done,phase} for each busy cycle, cycle 1 = first cycle after start.
  function automatic void build(input int hh, input int hl, input int rp);
    int h = (hh == 0) ? 1 : hh;
    int l = (hl == 0) ? 1 : hl;
    int f = (rp == 0) ? 1 : rp;
    exp_q.delete();
    for (int k = 0; k < f; k++)
      for (int p = 0; p < 4; p++)
        for (int n = 0; n < ((p % 2) ? l : h); n++)
          exp_q.push_back({(p % 2) == 0, 1'b1, 1'b0, 2'(p)});
  endfunction
  task automatic launch(input int hh, input int hl, input int rp);
    @(negedge clk);
    hold_hi = HOLD_W'(hh);
    hold_lo = HOLD_W'(hl);
    reps    = REP_W'(rp);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== IDLE_V) begin errors++; $display("FAIL reset_assert got=%b exp=%b", obs, IDLE_V); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== IDLE_V) begin errors++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs, IDLE_V); end
    end
  endtask
  task automatic test_frames;
    int tab_h[7] = '{3, 0, 2, 255, 1, 4, 0};
    int tab_l[7] = '{2, 0, 1, 1, 1, 4, 7};
    int tab_r[7] = '{1, 0, 3, 1, 15, 2, 2};
    for (int c = 0; c < 27; c++) begin
      int  hh, hl, rp, mid;
      bit  inj;
      hh  = (c < 7) ? tab_h[c] : int'($urandom_range(0, 6));
      hl  = (c < 7) ? tab_l[c] : int'($urandom_range(0, 6));
      rp  = (c < 7) ? tab_r[c] : int'($urandom_range(0, 4));
      inj = (c >= 5) && ($urandom_range(0, 1) == 1);
      build(hh, hl, rp);
      mid = exp_q.size() / 2;
      launch(hh, hl, rp);
      for (int i = 0; i < exp_q.size(); i++) begin
        start = inj && (i == mid);
        if (start) begin
          hold_hi = HOLD_W'($urandom);
          hold_lo = HOLD_W'($urandom);
          reps    = REP_W'($urandom);
        end
        checks++;
        if (obs !== exp_q[i]) begin
          errors++;
          $display("FAIL frame case=%0d cyc=%0d got=%b exp=%b", c, i + 1, obs, exp_q[i]);
        end
        @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (obs !== DONE_V) begin errors++; $display("FAIL done_pulse case=%0d got=%b exp=%b", c, obs, DONE_V); end
      @(negedge clk);
      checks++;
      if (obs !== IDLE_V) begin errors++; $display("FAIL after_done case=%0d got=%b exp=%b", c, obs, IDLE_V); end
    end
  endtask
  task automatic test_back_to_back;
    build(1, 1, 1);
    launch(1, 1, 1);
    repeat (4) @(negedge clk);
    checks++;
    if (obs !== DONE_V) begin errors++; $display("FAIL b2b_done got=%b exp=%b", obs, DONE_V); end
    hold_hi = 8'd2;
    hold_lo = 8'd3;
    reps    = 4'd2;
    start   = 1'b1;
    build(2, 3, 2);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs !== exp_q[i]) begin errors++; $display("FAIL b2b_frame cyc=%0d got=%b exp=%b", i + 1, obs, exp_q[i]); end
      @(negedge clk);
    end
    checks++;
    if (obs !== DONE_V) begin errors++; $display("FAIL b2b_done2 got=%b exp=%b", obs, DONE_V); end
    @(negedge clk);
  endtask
  task automatic test_abort;
    launch(3, 2, 2);
    repeat (5) @(negedge clk);
    checks++;
    if (obs !== 5'b11010) begin errors++; $display("FAIL abort_in_hi2 got=%b exp=%b", obs, 5'b11010); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (obs !== IDLE_V) begin errors++; $display("FAIL abort_idle cyc=%0d got=%b exp=%b", i, obs, IDLE_V); end
      @(negedge clk);
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (2) begin
      checks++;
      if (obs !== IDLE_V) begin errors++; $display("FAIL abort_drops_start got=%b exp=%b", obs, IDLE_V); end
      @(negedge clk);
    end
  endtask
  task automatic test_reset_mid;
    launch(3, 3, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 5'b01001) begin errors++; $display("FAIL rst_in_lo1 got=%b exp=%b", obs, 5'b01001); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE_V) begin errors++; $display("FAIL rst_async got=%b exp=%b", obs, IDLE_V); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== IDLE_V) begin errors++; $display("FAIL rst_no_done cyc=%0d got=%b exp=%b", i, obs, IDLE_V); end
    end
    build(2, 2, 1);
    launch(2, 2, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs !== exp_q[i]) begin errors++; $display("FAIL rst_refr cyc=%0d got=%b exp=%b", i + 1, obs, exp_q[i]); end
      @(negedge clk);
    end
    checks++;
    if (obs !== DONE_V) begin errors++; $display("FAIL rst_refr_done got=%b exp=%b", obs, DONE_V); end
  endtask
  initial begin
    test_reset;
    test_frames;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
